// File: rtl/motor_seq_pkg.sv
// Shared state encoding and default sizing for the motor command sequencer.
package motor_seq_pkg;

  localparam int unsigned K_TIMEW_DEF = 16;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_COAST  = 3'd1,
    ST_DBRAKE = 3'd2,
    ST_SWITCH = 3'd3,
    ST_EBRAKE = 3'd4
  } seq_state_e;

endpackage

// File: rtl/motor_seq_ramp.sv
// Slew limiter for the PWM magnitude: bounded rise per tick, immediate fall.
module motor_seq_ramp #(
  parameter int unsigned K_PWMRES = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_enable,
  input  logic                i_ramp_en,
  input  logic [K_PWMRES-1:0] i_ramp_step,
  input  logic                i_tick,
  input  logic [K_PWMRES-1:0] i_power,
  output logic [K_PWMRES-1:0] o_power
);

  localparam int unsigned SUMW = K_PWMRES + 1;

  logic [SUMW-1:0]     sum_c;
  logic [K_PWMRES-1:0] power_d;

  // Next magnitude; the sum carries one extra bit so a large step never wraps.
  always_comb begin
    sum_c   = SUMW'(o_power) + SUMW'(i_ramp_step);
    power_d = o_power;
    if (i_clear) begin
      power_d = '0;
    end else if (i_enable) begin
      if (!i_ramp_en || (i_power < o_power)) begin
        power_d = i_power;
      end else if (i_tick && (i_power > o_power)) begin
        power_d = (sum_c > SUMW'(i_power)) ? i_power : sum_c[K_PWMRES-1:0];
      end
    end
  end

  // Registered magnitude output.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_power <= '0;
    else       o_power <= power_d;
  end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Sequences direction reversals (coast, brake, switch) and emergency braking
// in front of the motor driver; all outputs registered.
module motor_cmd_sequencer
  import motor_seq_pkg::*;
#(
  parameter int unsigned K_PWMRES = 10,
  parameter int unsigned K_TIMEW  = K_TIMEW_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_brake,
  input  logic                i_reverse,
  input  logic [K_PWMRES-1:0] i_power,
  input  logic [K_TIMEW-1:0]  i_deadtime,
  input  logic [K_TIMEW-1:0]  i_brake_time,
  input  logic                i_ramp_en,
  input  logic [K_PWMRES-1:0] i_ramp_step,
  input  logic                i_tick,
  output logic                o_brake,
  output logic                o_reverse,
  output logic [K_PWMRES-1:0] o_power,
  output logic [2:0]          o_state,
  output logic                o_busy
);

  seq_state_e         state_q, state_d;
  logic [K_TIMEW-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               run_d;

  // Next-state, counter and direction; counter holds remaining cycles minus one,
  // loaded from the register bank at state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (i_brake) begin
      state_d = ST_EBRAKE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (i_reverse != dir_q) begin
            state_d = ST_COAST;
            cnt_d   = (i_deadtime == '0) ? '0 : i_deadtime - K_TIMEW'(1);
          end
        end
        ST_COAST: begin
          if (cnt_q == '0) begin
            state_d = ST_DBRAKE;
            cnt_d   = (i_brake_time == '0) ? '0 : i_brake_time - K_TIMEW'(1);
          end else begin
            cnt_d = cnt_q - K_TIMEW'(1);
          end
        end
        ST_DBRAKE: begin
          if (cnt_q == '0) begin
            state_d = ST_SWITCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - K_TIMEW'(1);
          end
        end
        ST_SWITCH, ST_EBRAKE: begin
          state_d = ST_RUN;
          cnt_d   = '0;
          dir_d   = i_reverse;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
    run_d = (state_d == ST_RUN);
  end

  // State, counter, direction and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      o_brake   <= 1'b0;
      o_reverse <= 1'b0;
      o_state   <= 3'd0;
      o_busy    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      o_brake   <= (state_d == ST_DBRAKE) || (state_d == ST_EBRAKE);
      o_reverse <= dir_d;
      o_state   <= 3'(state_d);
      o_busy    <= !run_d;
    end
  end

  // Magnitude path: forced to zero the same cycle the sequencer leaves RUN.
  motor_seq_ramp #(
    .K_PWMRES (K_PWMRES)
  ) u_ramp (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (!run_d),
    .i_enable    (run_d),
    .i_ramp_en   (i_ramp_en),
    .i_ramp_step (i_ramp_step),
    .i_tick      (i_tick),
    .i_power     (i_power),
    .o_power     (o_power)
  );

endmodule
